motion_sequencer: RTL and testbench

MOTION_SEQUENCER -- requirements
Module: motion_sequencer

---
 rtl/motion_sequencer.sv | 110 +++++++++++
 tb/tb_motion_sequencer.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/motion_sequencer.sv
// rtl/motion_sequencer.sv - drive sequencer: ramped speed, braking, post-stop dwell, obstacle emergency stop
module motion_sequencer #(
  parameter int             RAMP_TICKS  = 2_500_000,
  parameter int             DWELL_TICKS = 5_000_000,
  parameter logic [2:0]     MAX_SPEED   = 3'd5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  input  logic [1:0] cmd,
  input  logic       obstacle,
  output logic [2:0] direction,
  output logic [2:0] speed,
  output logic       moving
);

  typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_BRAKE, S_DWELL} state_t;
  typedef enum logic [1:0] {T_NONE, T_FWD, T_REV} target_t;

  localparam logic [2:0]  DIR_STOP   = 3'b000;
  localparam logic [2:0]  DIR_FWD    = 3'b001;
  localparam logic [2:0]  DIR_REV    = 3'b011;
  localparam logic [25:0] RAMP_LAST  = 26'(RAMP_TICKS - 1);
  localparam logic [25:0] DWELL_LAST = 26'(DWELL_TICKS - 1);

  state_t      state;
  target_t     target;
  target_t     next_target;
  target_t     dir_target;
  logic [25:0] tick_cnt;
  logic        ramp_step;
  logic        emergency;

  // A same-cycle command is visible to this cycle's decisions.
  always_comb begin
    next_target = target;
    if (cmd_valid) begin
      case (cmd)
        2'b01:   next_target = T_FWD;
        2'b10:   next_target = T_REV;
        2'b11:   next_target = T_NONE;
        default: next_target = target;
      endcase
    end
    dir_target = (direction == DIR_REV) ? T_REV : T_FWD;
    ramp_step  = (tick_cnt == RAMP_LAST);
    emergency  = obstacle && (direction == DIR_FWD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      target    <= T_NONE;
      direction <= DIR_STOP;
      speed     <= 3'd0;
      moving    <= 1'b0;
      tick_cnt  <= 26'd0;
    end else begin
      target <= next_target;
      case (state)
        S_IDLE: begin
          if (next_target == T_REV || (next_target == T_FWD && !obstacle)) begin
            state     <= S_DRIVE;
            direction <= (next_target == T_REV) ? DIR_REV : DIR_FWD;
            speed     <= 3'd1;
            moving    <= 1'b1;
            tick_cnt  <= 26'd0;
          end
        end
        S_DRIVE, S_BRAKE: begin
          if (emergency) begin
            state     <= S_DWELL;
            target    <= T_NONE;
            direction <= DIR_STOP;
            speed     <= 3'd0;
            moving    <= 1'b0;
            tick_cnt  <= 26'd0;
          end else if (state == S_DRIVE && next_target != dir_target) begin
            state    <= S_BRAKE;
            tick_cnt <= 26'd0;
          end else if (ramp_step) begin
            tick_cnt <= 26'd0;
            if (state == S_DRIVE) begin
              if (speed < MAX_SPEED) speed <= speed + 3'd1;
            end else if (speed == 3'd1) begin
              state     <= S_DWELL;
              direction <= DIR_STOP;
              speed     <= 3'd0;
              moving    <= 1'b0;
            end else begin
              speed <= speed - 3'd1;
            end
          end else begin
            tick_cnt <= tick_cnt + 26'd1;
          end
        end
        S_DWELL: begin
          if (tick_cnt == DWELL_LAST) begin
            state    <= S_IDLE;
            tick_cnt <= 26'd0;
          end else begin
            tick_cnt <= tick_cnt + 26'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_motion_sequencer.sv
// tb/tb_motion_sequencer.sv - self-checking bench for motion_sequencer against a phase/elapsed-time model
module tb_motion_sequencer;
  localparam int RAMP = 4;
  localparam int DWELL = 8;
  localparam int MAXS = 5;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic [1:0] cmd = 2'b00;
  logic       obstacle = 1'b0;
  logic [2:0] direction;
  logic [2:0] speed;
  logic       moving;

  int n_checks = 0;
  int n_fail = 0;

  // model: phase 0 idle, 1 drive, 2 brake, 3 dwell; tgt/dir 0 none, 1 fwd, 2 rev
  int m_phase, m_tgt, m_dir, m_el, m_speed, m_bstart;

  motion_sequencer #(.RAMP_TICKS(RAMP), .DWELL_TICKS(DWELL), .MAX_SPEED(3'(MAXS))) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd(cmd), .obstacle(obstacle),
    .direction(direction), .speed(speed), .moving(moving)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    m_phase = 0; m_tgt = 0; m_dir = 0; m_el = 0; m_speed = 0; m_bstart = 0;
  endfunction

  function automatic void model_step(input logic cv, input logic [1:0] c, input logic obs);
    int nt;
    int s;
    nt = m_tgt;
    if (cv && c != 2'b00) nt = (c == 2'b01) ? 1 : (c == 2'b10) ? 2 : 0;
    case (m_phase)
      0: begin
        m_tgt = nt;
        if (nt == 2 || (nt == 1 && !obs)) begin
          m_phase = 1; m_dir = nt; m_el = 0; m_speed = 1;
        end
      end
      1, 2: begin
        if (m_dir == 1 && obs) begin
          m_phase = 3; m_tgt = 0; m_dir = 0; m_speed = 0; m_el = 0;
        end else begin
          m_tgt = nt;
          if (m_phase == 1 && nt != m_dir) begin
            m_phase = 2; m_bstart = m_speed; m_el = 0;
          end else if (m_phase == 1) begin
            m_el++;
            m_speed = (1 + m_el / RAMP > MAXS) ? MAXS : 1 + m_el / RAMP;
          end else begin
            m_el++;
            s = m_bstart - m_el / RAMP;
            if (s == 0) begin
              m_phase = 3; m_dir = 0; m_speed = 0; m_el = 0;
            end else m_speed = s;
          end
        end
      end
      default: begin
        m_tgt = nt;
        m_el++;
        if (m_el == DWELL) begin m_phase = 0; m_el = 0; end
      end
    endcase
  endfunction

  function automatic logic [6:0] exp_out();
    logic [2:0] d;
    d = (m_dir == 1) ? 3'b001 : (m_dir == 2) ? 3'b011 : 3'b000;
    return {d, 3'(m_speed), (m_phase == 1 || m_phase == 2)};
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step(cmd_valid, cmd, obstacle);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic issue(input logic [1:0] c);
    cmd = c;
    cmd_valid = 1'b1;
  endtask

  task automatic run_model(input int n, input string name);
    for (int i = 0; i < n; i++) begin
      tick();
      n_checks++;
      if ({direction, speed, moving} !== exp_out()) begin
        n_fail++;
        $display("FAIL %s cyc %0d: dir/speed/moving got %b/%0d/%b want %b", name, i,
                 direction, speed, moving, exp_out());
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    #12;
    n_checks++;
    if ({direction, speed, moving} !== 7'd0) begin
      n_fail++;
      $display("FAIL reset_outputs got %b/%0d/%b want 000/0/0", direction, speed, moving);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_model(3, "reset_idle");
  endtask

  task automatic test_ramp();
    int want;
    obstacle = 1'b0;
    issue(2'b01);
    for (int k = 1; k <= 25; k++) begin
      tick();
      want = (1 + (k - 1) / RAMP > MAXS) ? MAXS : 1 + (k - 1) / RAMP;
      n_checks++;
      if (direction !== 3'b001 || speed !== 3'(want) || moving !== 1'b1) begin
        n_fail++;
        $display("FAIL ramp k=%0d got dir %b speed %0d want 001 speed %0d", k, direction, speed, want);
      end
    end
  endtask

  task automatic test_stop();
    issue(2'b11);
    for (int k = 1; k <= 32; k++) begin
      tick();
      if (k == 20) begin
        n_checks++;
        if (direction !== 3'b001 || speed !== 3'd1 || moving !== 1'b1) begin
          n_fail++;
          $display("FAIL stop_last_step got %b/%0d/%b want 001/1/1", direction, speed, moving);
        end
      end
      if (k >= 21) begin
        n_checks++;
        if ({direction, speed, moving} !== 7'd0) begin
          n_fail++;
          $display("FAIL stop_dwell k=%0d got %b/%0d/%b want 000/0/0", k, direction, speed, moving);
        end
      end
    end
    model_reset();
  endtask

  task automatic test_reversal();
    logic [2:0] prev;
    issue(2'b01);
    run_model(9, "rev_ramp");
    n_checks++;
    if (speed !== 3'd3) begin
      n_fail++;
      $display("FAIL rev_pre_speed got %0d want 3", speed);
    end
    prev = direction;
    issue(2'b10);
    for (int k = 1; k <= 30; k++) begin
      tick();
      n_checks++;
      if ({direction, speed, moving} !== exp_out() || (prev == 3'b001 && direction == 3'b011)) begin
        n_fail++;
        $display("FAIL reversal k=%0d got %b/%0d/%b want %b prev %b", k, direction, speed, moving, exp_out(), prev);
      end
      if (k == 22) begin
        n_checks++;
        if (direction !== 3'b011 || speed !== 3'd1) begin
          n_fail++;
          $display("FAIL reversal_restart got %b/%0d want 011/1", direction, speed);
        end
      end
      prev = direction;
    end
  endtask

  task automatic test_obstacle();
    issue(2'b11);
    run_model(40, "obs_settle");
    issue(2'b01);
    run_model(13, "obs_ramp");
    obstacle = 1'b1;
    tick();
    n_checks++;
    if ({direction, speed, moving} !== 7'd0) begin
      n_fail++;
      $display("FAIL obstacle_stop got %b/%0d/%b want 000/0/0", direction, speed, moving);
    end
    obstacle = 1'b0;
    run_model(20, "obs_hold_idle");
    n_checks++;
    if (direction !== 3'b000) begin
      n_fail++;
      $display("FAIL obstacle_no_restart got dir %b want 000", direction);
    end
    obstacle = 1'b1;
    issue(2'b01);
    run_model(3, "obs_go_blocked");
    obstacle = 1'b0;
    run_model(2, "obs_go_cleared");
    issue(2'b11);
    run_model(40, "obs_final_settle");
  endtask

  task automatic test_reverse_obstacle();
    issue(2'b10);
    run_model(9, "revobs_ramp");
    obstacle = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      n_checks++;
      if (direction !== 3'b011 || moving !== 1'b1 || {direction, speed, moving} !== exp_out()) begin
        n_fail++;
        $display("FAIL reverse_ignores_obstacle k=%0d got %b/%0d/%b want %b", k, direction, speed, moving, exp_out());
      end
    end
    obstacle = 1'b0;
    issue(2'b11);
    run_model(40, "revobs_settle");
    issue(2'b01);
    run_model(5, "revobs_fwd");
    issue(2'b01);
    obstacle = 1'b1;
    tick();
    n_checks++;
    if ({direction, speed, moving} !== 7'd0) begin
      n_fail++;
      $display("FAIL emergency_beats_go got %b/%0d/%b want 000/0/0", direction, speed, moving);
    end
    obstacle = 1'b0;
    run_model(20, "revobs_dwell");
  endtask

  task automatic test_async_reset();
    issue(2'b01);
    run_model(6, "areset_ramp");
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({direction, speed, moving} !== 7'd0) begin
      n_fail++;
      $display("FAIL async_reset got %b/%0d/%b want 000/0/0", direction, speed, moving);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    run_model(10, "areset_idle");
    issue(2'b01);
    tick();
    n_checks++;
    if (direction !== 3'b001 || speed !== 3'd1) begin
      n_fail++;
      $display("FAIL first_cmd_after_reset got %b/%0d want 001/1", direction, speed);
    end
    issue(2'b11);
    run_model(40, "areset_settle");
  endtask

  task automatic test_random();
    logic [2:0] prev;
    prev = direction;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(15) == 0) issue(2'($urandom_range(3)));
      if ($urandom_range(40) == 0) obstacle = ~obstacle;
      tick();
      n_checks++;
      if ({direction, speed, moving} !== exp_out() ||
          !(direction inside {3'b000, 3'b001, 3'b011}) ||
          (prev == 3'b001 && direction == 3'b011) || (prev == 3'b011 && direction == 3'b001)) begin
        n_fail++;
        $display("FAIL random cyc %0d got %b/%0d/%b want %b prev %b", i, direction, speed, moving, exp_out(), prev);
      end
      prev = direction;
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_ramp();
    test_stop();
    test_reversal();
    test_obstacle();
    test_reverse_obstacle();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
